universal_shift_reg: RTL
========================

# universal_shift_reg

Parametrised edge-triggered register bank, the next generation of the single-bit master-slave D flip-flop. It holds WIDTH bits with complementary outputs and supports hold, parallel load, shift-left and shift-right modes with serial in/out. A load-tracking bit counter flags when a parallel word has been fully shifted out, so the block can act as a serialiser or deserialiser in lab designs.

## Interface
- WIDTH, 8: register width in bits, at least 2.
- RESET_VAL, 0: WIDTH-bit value loaded into Q by reset.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  clock enable; 0 means hold everything.
- MODE  in  2  0 = hold, 1 = load, 2 = shift left (toward MSB), 3 = shift right (toward LSB).
- D  in  WIDTH  parallel load data.
- SIL  in  1  serial input entering bit 0 on shift-left.
- SIR  in  1  serial input entering bit WIDTH-1 on shift-right.
- Q  out  WIDTH  register contents.
- nQ  out  WIDTH  bitwise complement of Q, always.
- SOL  out  1  equals Q[WIDTH-1], the bit leaving on shift-left.
- SOR  out  1  equals Q[0], the bit leaving on shift-right.
- CNT  out  $clog2(WIDTH+1)  number of loaded bits not yet shifted out.
- DONE  out  1  high when CNT == 0.
- ROT  in  1  rotate select; present only when SHIFT_REG_ROTATE_EN is defined.

## Operation
- Reset is synchronous and active-high. Priority is RST > EN == 0 > MODE.
- On a rising edge with RST = 1: Q = RESET_VAL, nQ = ~RESET_VAL and CNT = 0, so DONE = 1. This applies in any mode and mid-shift, and discards a pending count.
- EN = 0, or MODE = 0: Q and CNT are unchanged.
- MODE = 1 (load): Q = D and CNT = WIDTH.
- MODE = 2 (shift left): Q = {Q[WIDTH-2:0], SIL}.
- MODE = 3 (shift right): Q = {SIR, Q[WIDTH-1:1]}.
- On any shift, CNT decrements and saturates at 0. Shifting with CNT = 0 still moves the data, and CNT stays 0.
- CNT arithmetic is unsigned. A load while CNT > 0 restarts the count at WIDTH.
- nQ is never independent state: it always equals ~Q, including during and after reset.
- SOL, SOR, CNT and DONE are combinational from the registered state. There are no combinational paths from inputs to outputs.

## Timing
- Latency is 1 cycle: an input sampled at edge n is visible on Q at edge n.
- After a load, DONE falls in the same cycle Q takes D. It rises at the edge of the WIDTH-th subsequent shift.
- Serialising a word takes exactly WIDTH shift cycles. SOL or SOR before the first shift presents the first bit.
- RST asserted in the same cycle as a load: the reset wins and D is ignored.

## Configuration
- Macro: SHIFT_REG_ROTATE_EN.
- Defined:
  - The ROT port exists.
  - With ROT = 1, shift-left uses Q[WIDTH-1] in place of SIL, and shift-right uses Q[0] in place of SIR.
  - CNT still decrements on rotate.
- Undefined:
  - There is no ROT port.
  - Shifts always take SIL or SIR.

## Structure
- Package shift_reg_pkg holds:
  - the MODE encodings: MODE_HOLD = 2'd0, MODE_LOAD = 2'd1, MODE_SHL = 2'd2, MODE_SHR = 2'd3;
  - a function computing the CNT width.
- One sub-module, reg_bit: a single enabled D-flip-flop with synchronous reset value and complementary output.
  - It is instantiated WIDTH times through a generate loop.
  - The next-state multiplexer and the counter live in the top level.

## Test plan
Benches use WIDTH = 8 and RESET_VAL = 8'hA5.
- Reset:
  - Stimulus: RST = 1 for 1 cycle in any mode.
  - Response: Q = 8'hA5, nQ = 8'h5A, CNT = 0, DONE = 1, SOL = 1, SOR = 1.
- Load:
  - Stimulus: EN = 1, MODE = 1, D = 8'h3C.
  - Response: next cycle Q = 8'h3C, nQ = 8'hC3, CNT = 8, DONE = 0.
- Serialise left:
  - Stimulus: load 8'h96, then 8 cycles of MODE = 2 with SIL = 0.
  - Response: SOL sequence is 1,0,0,1,0,1,1,0. After 8 shifts CNT = 0, DONE = 1 and Q = 8'h00. A 9th shift leaves CNT = 0.
- Deserialise right:
  - Stimulus: from reset, 8 cycles of MODE = 3 with SIR = 1,1,0,0,1,0,1,0.
  - Response: Q = 8'h53, and CNT stays 0 throughout.
- Hold and enable:
  - Stimulus: load 8'hF0, then EN = 0 with MODE = 2 for 3 cycles; then EN = 1 with MODE = 0.
  - Response: Q stays 8'hF0 and CNT stays 8 throughout.
- Reset mid-shift, and rotate:
  - Stimulus: load 8'h81, shift right 3 times, then assert RST.
  - Response: Q = 8'hA5 and CNT = 0 on the next cycle.
  - With SHIFT_REG_ROTATE_EN defined and ROT = 1, rotate-left of 8'h81 gives 8'h03.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: MODE encodings and
// the width helper for the load-tracking bit counter.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_SHL  = 2'd2;
  localparam logic [1:0] MODE_SHR  = 2'd3;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/reg_bit.sv
// Single enabled D flip-flop with synchronous reset value and a
// complementary output that is always the inverse of the stored bit.
module reg_bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic q_n
);

  logic q_q;
  logic q_d;

  // Next value: take d when enabled, otherwise keep the stored bit.
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // Storage with synchronous reset taking priority over enable.
  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_BIT;
    else     q_q <= q_d;
  end

  assign q   = q_q;
  assign q_n = ~q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, parallel load, shift left and shift right
// with serial in/out, complementary outputs and a counter of loaded bits not
// yet shifted out (DONE when it reaches zero).
// Optional feature macro: SHIFT_REG_ROTATE_EN adds the ROT input, which feeds
// the outgoing bit back in place of SIL/SIR during shifts.
module universal_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = cnt_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             SOL,
  output logic             SOR,
  output logic [CNT_W-1:0] CNT,
  output logic             DONE
);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] nq_w;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sil_eff;
  logic             sir_eff;

`ifdef SHIFT_REG_ROTATE_EN
  assign sil_eff = ROT ? q_w[WIDTH-1] : SIL;
  assign sir_eff = ROT ? q_w[0]       : SIR;
`else
  assign sil_eff = SIL;
  assign sir_eff = SIR;
`endif

  // Data next-state mux; EN gating is applied inside each bit cell.
  always_comb begin
    q_d = q_w;
    case (MODE)
      MODE_LOAD: q_d = D;
      MODE_SHL:  q_d = {q_w[WIDTH-2:0], sil_eff};
      MODE_SHR:  q_d = {sir_eff, q_w[WIDTH-1:1]};
      default:   q_d = q_w;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      reg_bit #(
        .RESET_BIT (RESET_VAL[i])
      ) u_bit (
        .clk (CLK),
        .rst (RST),
        .en  (EN),
        .d   (q_d[i]),
        .q   (q_w[i]),
        .q_n (nq_w[i])
      );
    end
  endgenerate

  // Counter next state: load restarts at WIDTH, shifts count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (EN) begin
      case (MODE)
        MODE_LOAD: cnt_d = CNT_W'(WIDTH);
        MODE_SHL,
        MODE_SHR:  cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  // Counter register; reset discards any pending count.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Q    = q_w;
  assign nQ   = nq_w;
  assign SOL  = q_w[WIDTH-1];
  assign SOR  = q_w[0];
  assign CNT  = cnt_q;
  assign DONE = (cnt_q == '0);

endmodule
